// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder (lower-part OR, segmented registered carry), STAGES cycles latency,
// global stall when output is held; optional error monitor under APPROX_ADD_ERRMON_EN.
module approx_add_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  input  logic             err_clr,
  output logic [31:0]      err_cnt,
  output logic [WIDTH:0]   err_max,
  output logic [31:0]      txn_cnt
);

  localparam int K   = APPROX_BITS;
  localparam int UW  = WIDTH - K;
  localparam int SEG = (UW + STAGES - 1) / STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             cy;
`ifdef APPROX_ADD_ERRMON_EN
    logic [WIDTH:0]   ref_sum;
`endif
  } stage_t;

  stage_t           src0;
  stage_t           src_c [STAGES];
  stage_t           nxt_c [STAGES];
  stage_t           stg_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_d;
  logic [WIDTH-1:0]  lo_res;
  logic              lo_cy;
  logic              advance;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;
  assign sum       = {stg_q[STAGES-1].cy, stg_q[STAGES-1].res};
  assign vld_d     = {vld_q, in_valid};

  // Lower part and mode are fully resolved before the first register.
  generate
    if (K > 0) begin : g_lo
      logic [K:0] lo_exact;
      assign lo_exact = {1'b0, a[K-1:0]} + {1'b0, b[K-1:0]};
      assign lo_res   = {{(WIDTH-K){1'b0}}, (mode ? (a[K-1:0] | b[K-1:0]) : lo_exact[K-1:0])};
      assign lo_cy    = mode ? (a[K-1] & b[K-1]) : lo_exact[K];
    end else begin : g_no_lo
      assign lo_res = '0;
      assign lo_cy  = 1'b0;
    end
  endgenerate

  always_comb begin
    src0     = '0;
    src0.a   = a;
    src0.b   = b;
    src0.res = lo_res;
    src0.cy  = lo_cy;
`ifdef APPROX_ADD_ERRMON_EN
    src0.ref_sum = {1'b0, a} + {1'b0, b};
`endif
  end

  // Each stage adds its own slice of the upper part; an empty trailing slice just forwards the carry.
  genvar gs;
  generate
    for (gs = 0; gs < STAGES; gs++) begin : g_stg
      localparam int LO  = K + gs * SEG;
      localparam int AVL = (LO >= WIDTH) ? 0 : (WIDTH - LO);
      localparam int W   = (gs == STAGES - 1) ? AVL : ((SEG < AVL) ? SEG : AVL);

      if (gs == 0) begin : g_first
        assign src_c[gs] = src0;
      end else begin : g_next
        assign src_c[gs] = stg_q[gs-1];
      end

      if (W > 0) begin : g_add
        logic [W:0] seg_sum;
        stage_t     nxt;
        assign seg_sum = {1'b0, src_c[gs].a[LO +: W]} + {1'b0, src_c[gs].b[LO +: W]}
                       + {{W{1'b0}}, src_c[gs].cy};
        always_comb begin
          nxt              = src_c[gs];
          nxt.res[LO +: W] = seg_sum[W-1:0];
          nxt.cy           = seg_sum[W];
        end
        assign nxt_c[gs] = nxt;
      end else begin : g_pass
        assign nxt_c[gs] = src_c[gs];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
    end else if (advance) begin
      vld_q <= vld_d[STAGES-1:0];
      for (int s = 0; s < STAGES; s++) stg_q[s] <= nxt_c[s];
    end
  end

`ifdef APPROX_ADD_ERRMON_EN
  logic           deliver;
  logic [WIDTH:0] ref_q;
  logic [WIDTH:0] abs_err;

  assign deliver = out_valid && out_ready;
  assign ref_q   = stg_q[STAGES-1].ref_sum;
  assign abs_err = (ref_q >= sum) ? (ref_q - sum) : (sum - ref_q);

  // Clear beats a same-cycle delivery: that result is dropped from the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
      txn_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_max <= '0;
      txn_cnt <= '0;
    end else if (deliver) begin
      if (txn_cnt != '1) txn_cnt <= txn_cnt + 32'd1;
      if ((abs_err != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
      if (abs_err > err_max) err_max <= abs_err;
    end
  end
`else
  assign err_cnt = '0;
  assign err_max = '0;
  assign txn_cnt = '0;
`endif

  logic unused_sink;
  assign unused_sink = ^{stg_q[STAGES-1].a, stg_q[STAGES-1].b, mode, err_clr, vld_d[STAGES]};

endmodule

// File: tb/tb_approx_add_pipe.sv
// Randomized and directed bench for approx_add_pipe with an arithmetic reference model and scoreboard.
module tb_approx_add_pipe;

  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, mode, out_ready, err_clr;
  logic [15:0] a, b;
  logic        in_ready, out_valid;
  logic [16:0] sum, err_max;
  logic [31:0] err_cnt, txn_cnt;
  logic        in_ready1, out_valid1, in_ready3, out_valid3;
  logic [16:0] sum1, err_max1, sum3, err_max3;
  logic [31:0] err_cnt1, txn_cnt1, err_cnt3, txn_cnt3;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(16), .APPROX_BITS(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .err_clr(err_clr),
    .err_cnt(err_cnt), .err_max(err_max), .txn_cnt(txn_cnt));

  approx_add_pipe #(.WIDTH(16), .APPROX_BITS(0), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .err_clr(err_clr),
    .err_cnt(err_cnt1), .err_max(err_max1), .txn_cnt(txn_cnt1));

  approx_add_pipe #(.WIDTH(16), .APPROX_BITS(5), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid3), .out_ready(1'b1), .sum(sum3), .err_clr(err_clr),
    .err_cnt(err_cnt3), .err_max(err_max3), .txn_cnt(txn_cnt3));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: OR the low k bits, inject a[k-1]&b[k-1] as carry, add the rest exactly.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic m, input int k);
    logic [31:0] lo, up, c;
    if (!m || k == 0) return {1'b0, x} + {1'b0, y};
    lo = (32'(x) | 32'(y)) & ((32'd1 << k) - 32'd1);
    c  = (32'(x) >> (k - 1)) & (32'(y) >> (k - 1)) & 32'd1;
    up = (32'(x) >> k) + (32'(y) >> k) + c;
    return 17'((up << k) | lo);
  endfunction

  typedef struct {
    logic [16:0] s;
    logic [16:0] ex;
    int          acc;
    int          stl;
  } ent_t;

  ent_t        q[$];
  ent_t        ent;
  int          cyc = 8;
  int          stalls = 0;
  logic        prev_stall = 1'b0, head_seen = 1'b0, popped;
  logic [16:0] prev_sum, last_sum = '0, d;
  logic [31:0] mc = '0, mt = '0;
  logic [16:0] mx = '0;
  logic        hv[8];
  logic [16:0] h1[8], h3[8];

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
      head_seen  = 1'b0;
      mc = '0; mx = '0; mt = '0;
      for (int i = 0; i < 8; i++) hv[i] = 1'b0;
    end else begin
      cyc++;
      popped = 1'b0;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, prev_sum);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("stale_result", out_valid, 0);
        else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (stalls == q[0].stl) chk("latency", cyc - q[0].acc, STAGES);
          end
          if (out_ready) begin
            chk("sum", sum, q[0].s);
            last_sum  = sum;
            ent       = q.pop_front();
            popped    = 1'b1;
            head_seen = 1'b0;
          end
        end
      end
`ifdef APPROX_ADD_ERRMON_EN
      chk("err_cnt", err_cnt, mc);
      chk("err_max", err_max, mx);
      chk("txn_cnt", txn_cnt, mt);
`else
      chk("err_cnt_off", err_cnt, 0);
      chk("err_max_off", err_max, 0);
      chk("txn_cnt_off", txn_cnt, 0);
`endif
      if (err_clr) begin
        mc = '0; mx = '0; mt = '0;
      end else if (popped) begin
        d = (ent.ex >= ent.s) ? (ent.ex - ent.s) : (ent.s - ent.ex);
        if (mt != '1) mt++;
        if (d != 0 && mc != '1) mc++;
        if (d > mx) mx = d;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      if (prev_stall) stalls++;
      if (in_valid && in_ready)
        q.push_back('{s: model(a, b, mode, 4), ex: {1'b0, a} + {1'b0, b}, acc: cyc, stl: stalls});

      // Secondary configurations never stall: fixed-latency history check.
      chk("u1_in_ready", in_ready1, 1);
      chk("u3_in_ready", in_ready3, 1);
      chk("u1_valid", out_valid1, hv[(cyc - 1) % 8]);
      if (hv[(cyc - 1) % 8]) chk("u1_sum", sum1, h1[(cyc - 1) % 8]);
      chk("u3_valid", out_valid3, hv[(cyc - 3) % 8]);
      if (hv[(cyc - 3) % 8]) chk("u3_sum", sum3, h3[(cyc - 3) % 8]);
      chk("u1_err_cnt", err_cnt1, 0);
      chk("u1_err_max", err_max1, 0);
      hv[cyc % 8] = in_valid;
      h1[cyc % 8] = {1'b0, a} + {1'b0, b};
      h3[cyc % 8] = model(a, b, mode, 5);
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic m);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; mode = m;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #2;
  endtask

  task automatic chk_stats(input string nm, input logic [31:0] c, input logic [16:0] m,
                           input logic [31:0] t);
`ifdef APPROX_ADD_ERRMON_EN
    chk({nm, "_cnt"}, err_cnt, c);
    chk({nm, "_max"}, err_max, m);
    chk({nm, "_txn"}, txn_cnt, t);
`else
    chk({nm, "_cnt"}, err_cnt, 0);
    chk({nm, "_max"}, err_max, 0);
    chk({nm, "_txn"}, txn_cnt, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk_stats("rst", 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    chk("model_pin_a", model(16'h0008, 16'h0008, 1'b1, 4), 17'h00018);
    chk("model_pin_b", model(16'hFFFF, 16'hFFFF, 1'b1, 4), 17'h1FFFF);

    send(16'h000F, 16'h0001, 1'b1); drain();
    chk("lit_basic", last_sum, 17'h0000F);
    chk_stats("basic", 1, 1, 1);
    send(16'h0008, 16'h0008, 1'b1); drain();
    chk("lit_carry", last_sum, 17'h00018);
    chk_stats("carry", 2, 8, 2);
    send(16'hFFFF, 16'hFFFF, 1'b1); drain();
    chk("lit_allones", last_sum, 17'h1FFFF);
    chk_stats("allones", 3, 8, 3);
    send(16'hFFFF, 16'h0001, 1'b0); drain();
    chk("lit_exact", last_sum, 17'h10000);
    chk_stats("exact", 3, 8, 4);

    // Clear held across a delivery: that result must not be counted.
    err_clr = 1'b1;
    send(16'h0003, 16'h0001, 1'b1); drain();
    err_clr = 1'b0;
    @(posedge clk); #2;
    chk("lit_clr_sum", last_sum, 17'h00003);
    chk_stats("clr", 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); mode = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk_stats("exact_stream", 0, 0, 1000);

    err_clr = 1'b1; @(posedge clk); #1 err_clr = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
    join
    drain();
`ifdef APPROX_ADD_ERRMON_EN
    chk("bp_txn", txn_cnt, 8);
`else
    chk("bp_txn", txn_cnt, 0);
`endif

    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      a         = 16'($urandom);
      b         = 16'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      err_clr   = ($urandom_range(39) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    drain();

    // Reset with two beats held in flight.
    send(16'h1234, 16'h0F0F, 1'b1); drain();
    out_ready = 1'b0;
    send(16'h0011, 16'h0022, 1'b1);
    send(16'h0033, 16'h0044, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    chk_stats("midrst", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    send(16'h00F0, 16'h0F00, 1'b1); drain();
    chk("post_rst_sum", last_sum, 17'h00FF0);
    chk_stats("post_rst", 0, 0, 1);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_add_pipe.md
# approx_add_pipe

Parametrised, pipelined approximate adder: a generalisation of the fixed 8-bit combinational approximate adders in the library to any operand width, with a configurable lower-part-OR approximation depth, a runtime exact/approximate mode, a registered carry chain split over a configurable number of stages, and valid/ready flow control. It sits as a drop-in arithmetic unit in datapaths that trade accuracy for area and delay. It can optionally self-measure its error against an exact reference sum.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (≥2).
- APPROX_BITS, 4, low bits computed approximately (0..WIDTH-1); 0 = always exact.
- STAGES, 2, pipeline stages (1..WIDTH-APPROX_BITS); also the number of upper-part carry segments.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  1  sampled with the beat; 1 = approximate, 0 = exact.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  result.
- err_clr  in  1  synchronous clear of error statistics.
- err_cnt  out  32  erroneous results seen (saturating).
- err_max  out  WIDTH+1  worst-case absolute error seen.
- txn_cnt  out  32  results delivered (saturating).

## Operation
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Approximate arithmetic (mode=1, K=APPROX_BITS>0):
  - sum[i] = a[i] | b[i] for i<K.
  - Carry into bit K = a[K-1] & b[K-1].
  - sum[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K] + carry, full carry-out into sum[WIDTH].
- Exact arithmetic (mode=0 or K=0): sum = a + b, WIDTH+1 bits, no truncation.
- Upper part (WIDTH-K bits) split into STAGES segments of ceil((WIDTH-K)/STAGES) bits; the last segment takes the remainder.
  - Stage s adds segment s with the carry registered from stage s-1.
  - Not-yet-used operand bits and completed result bits are delayed alongside.
  - Lower part and mode are resolved in stage 1.
- Flow control: single global advance enable = !(out_valid && !out_ready).
  - in_ready = advance.
  - Every stage valid bit and data register moves only when advance=1.
  - While stalled, sum and out_valid hold stable.
  - Bubbles propagate as invalid stages; no compaction.

## Timing
- Reset values (asynchronous, rst_n low): out_valid=0, in_ready=1, sum=0, all stage valid bits 0, err_cnt=0, err_max=0, txn_cnt=0.
- Latency: beat accepted at edge n gives out_valid=1 after edge n+STAGES-1, with no stall.
- Throughput: one beat per cycle when out_ready stays 1.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_valid to in_ready.
- Simultaneous accept and deliver in one cycle is legal with full throughput.
- rst_n asserted mid-operation: all in-flight beats are discarded. After release, the first result appears STAGES cycles after the next accepted beat.
- mode is latched per beat, so mixed modes in flight are legal.

## Configuration
- APPROX_ADD_ERRMON_EN defined:
  - An exact sum travels with each beat.
  - On each delivered result, txn_cnt increments.
  - err_cnt increments when sum differs from the exact sum.
  - err_max updates to max(err_max, |exact − sum|).
  - Counters saturate at all-ones.
  - err_clr=1 zeros err_cnt, err_max and txn_cnt at the next edge. If a result is delivered in the same cycle, the clear wins and that result is not counted.
- APPROX_ADD_ERRMON_EN undefined: no reference datapath; err_cnt, err_max and txn_cnt are tied to 0; err_clr is ignored.

## Test plan
Defaults WIDTH=16, APPROX_BITS=4, STAGES=2; APPROX_ADD_ERRMON_EN defined unless noted.
- Approximate basic: a=0x000F, b=0x0001, mode=1 → sum=0x0000F two cycles later; err_cnt=1, err_max=1.
- Carry injection: a=0x0008, b=0x0008, mode=1 → sum=0x00018; err_max=8. a=0xFFFF, b=0xFFFF, mode=1 → sum=0x1FFFF.
- Exact mode: a=0xFFFF, b=0x0001, mode=0 → sum=0x10000; err_cnt unchanged. A 1000-beat random mode=0 stream must match a+b exactly.
- Backpressure: stream 8 beats, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 and sum stable during the stall; all 8 results delivered in order; txn_cnt=8.
- Reset mid-stream: rst_n low with 2 beats in flight → out_valid=0 and counters 0 immediately; no stale result after release.
- Macro undefined, and STAGES=1 / APPROX_BITS=0 sweep: error ports read 0; latency 1; results equal exact a+b.
